// File: rtl/key_input_pkg.sv
// Shared types and width helpers for the debounced key front end.
package key_input_pkg;

    // Per-key debounce FSM states.
    typedef enum logic [2:0] {
        Idle,
        PressWait,
        Pressed,
        LongHeld,
        ReleaseWait
    } key_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed for a prescaler counting 0..div-1.
    function automatic int unsigned div_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: two-flop synchroniser, polarity normalisation, tick-driven debounce FSM
// with registered press/release/long pulses.
module key_debounce_fsm
    import key_input_pkg::*;
#(
    parameter int unsigned STABLE_CNT     = 20,
    parameter int unsigned LONG_CNT       = 1000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned    DW   = cnt_width(STABLE_CNT);
    localparam int unsigned    LW   = cnt_width(LONG_CNT);
    localparam logic [DW-1:0]  DMAX = DW'(STABLE_CNT);
    localparam logic [LW-1:0]  LMAX = LW'(LONG_CNT);
    localparam logic [DW-1:0]  DONE = DW'(1);

    logic [1:0]    sync_q;
    logic          p;
    key_state_e    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d, dcnt_inc;
    logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic          from_long_q, from_long_d;
    logic          press_q, press_d, release_q, release_d, long_q, long_d;
    logic          go_release;

    // Two-flop synchroniser, reset to the released raw level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {2{KEY_ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    // p = 1 means pressed regardless of board polarity.
    assign p = sync_q[1] ^ KEY_ACTIVE_LOW;

    // Saturating increments; the FSM leaves the counting state on reaching the limit anyway.
    assign dcnt_inc = (dcnt_q == DMAX) ? dcnt_q : dcnt_q + DW'(1);
    assign lcnt_inc = (lcnt_q == LMAX) ? lcnt_q : lcnt_q + LW'(1);

    // Next-state and pulse decode, only acting on tick cycles.
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        lcnt_d      = lcnt_q;
        from_long_d = from_long_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        go_release  = 1'b0;
        if (tick) begin
            case (state_q)
                Idle: begin
                    if (p) begin
                        if (DMAX == DONE) begin
                            state_d = Pressed;
                            press_d = 1'b1;
                            lcnt_d  = '0;
                        end else begin
                            state_d = PressWait;
                            dcnt_d  = DONE;
                        end
                    end
                end
                PressWait: begin
                    if (p) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_inc == DMAX) begin
                            state_d = Pressed;
                            press_d = 1'b1;
                            lcnt_d  = '0;
                        end
                    end else begin
                        state_d = Idle;
                        dcnt_d  = '0;
                    end
                end
                Pressed: begin
                    if (p) begin
                        lcnt_d = lcnt_inc;
                        if (lcnt_inc == LMAX) begin
                            state_d = LongHeld;
                            long_d  = 1'b1;
                        end
                    end else begin
                        from_long_d = 1'b0;
                        go_release  = 1'b1;
                    end
                end
                LongHeld: begin
                    if (!p) begin
                        from_long_d = 1'b1;
                        go_release  = 1'b1;
                    end
                end
                ReleaseWait: begin
                    if (!p) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_inc == DMAX) begin
                            state_d   = Idle;
                            release_d = 1'b1;
                            dcnt_d    = '0;
                        end
                    end else begin
                        // Glitch: resume where we were; lcnt keeps its frozen value.
                        state_d = from_long_q ? LongHeld : Pressed;
                    end
                end
                default: begin
                    state_d = Idle;
                    dcnt_d  = '0;
                end
            endcase
            if (go_release) begin
                if (DMAX == DONE) begin
                    state_d   = Idle;
                    release_d = 1'b1;
                    dcnt_d    = '0;
                end else begin
                    state_d = ReleaseWait;
                    dcnt_d  = DONE;
                end
            end
        end
    end

    // State, counters and registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= Idle;
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            from_long_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            from_long_q <= from_long_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign key_level   = (state_q == Pressed) || (state_q == LongHeld) ||
                         (state_q == ReleaseWait);
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Key input front end: shared sample prescaler, one debouncer per key, and the sel toggle.
module key_input_ctrl
    import key_input_pkg::*;
#(
    parameter int unsigned N_KEYS         = 4,
    parameter int unsigned SAMPLE_DIV     = 50000,
    parameter int unsigned STABLE_CNT     = 20,
    parameter int unsigned LONG_CNT       = 1000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              sel
);

    localparam int unsigned   PW   = div_width(SAMPLE_DIV);
    localparam logic [PW-1:0] PMAX = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0] pcnt_q;
    logic          tick;
    logic          sel_q;

    assign tick = (pcnt_q == PMAX);

    // Free-running prescaler 0..SAMPLE_DIV-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PW'(1);
        end
    end

    // sel flips one clock after each key-0 press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q <= 1'b0;
        end else if (key_press[0]) begin
            sel_q <= ~sel_q;
        end
    end

    assign sel = sel_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .STABLE_CNT    (STABLE_CNT),
            .LONG_CNT      (LONG_CNT),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
        ) u_key (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .key_in     (key_in[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_input_ctrl.sv
// Scoreboard bench for key_input_ctrl: stimulus queues expected pulses with time windows,
// a negedge monitor matches every observed pulse against the queue.
module tb_key_input_ctrl;

    localparam int NK = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_level, key_press, key_release, key_long;
    logic          sel;

    always #5 clk = ~clk;

    key_input_ctrl #(
        .N_KEYS        (NK),
        .SAMPLE_DIV    (4),
        .STABLE_CNT    (3),
        .LONG_CNT      (10),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .sel        (sel)
    );

    // kind: 0 press, 1 release, 2 long. Press/release: absolute cycle window [lo,hi].
    // Long: lo is the required distance in clocks from that key's press pulse.
    typedef struct {
        int kind;
        int key;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_press[NK];
    bit   sel_model = 1'b0;
    bit   sel_pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int key, input int lo, input int hi);
        exp_t e;
        e.kind = kind;
        e.key  = key;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic pulse_of(input int kind, input int key);
        case (kind)
            0:       return key_press[key];
            1:       return key_release[key];
            default: return key_long[key];
        endcase
    endfunction

    task automatic match(input int kind, input int key);
        int   idx;
        exp_t e;
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (idx < 0 && exp_q[j].kind == kind && exp_q[j].key == key) idx = j;
        end
        n_cmp++;
        if (idx < 0) begin
            n_err++;
            $display("FAIL unexpected_pulse: kind %0d on key %0d at cycle %0d, required none",
                     kind, key, cyc);
            return;
        end
        e = exp_q[idx];
        exp_q.delete(idx);
        if (kind == 2) begin
            n_cmp--;
            check($sformatf("long_delay_k%0d", key), cyc - last_press[key], e.lo);
        end else if (cyc < e.lo || cyc > e.hi) begin
            n_err++;
            $display("FAIL pulse_time: kind %0d key %0d at cycle %0d, required %0d..%0d",
                     kind, key, cyc, e.lo, e.hi);
        end
        if (kind == 0) begin
            last_press[key] = cyc;
            check($sformatf("press_level_k%0d", key), int'(key_level[key]), 1);
            if (key == 0) begin
                sel_model   = ~sel_model;
                sel_pending = 1'b1;
            end
        end else if (kind == 1) begin
            check($sformatf("release_level_k%0d", key), int'(key_level[key]), 0);
        end
    endtask

    // Monitor: every pulse must consume a matching expectation.
    always @(negedge clk) begin
        if (!reset) begin
            sel_model   = 1'b0;
            sel_pending = 1'b0;
        end else begin
            if (sel_pending) begin
                check("sel_toggle", int'(sel), int'(sel_model));
                sel_pending = 1'b0;
            end
            for (int i = 0; i < NK; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (pulse_of(k, i)) match(k, i);
                end
            end
        end
    end

    initial begin
        int k;
        int j;
        for (int i = 0; i < NK; i++) last_press[i] = 0;

        // Reset state.
        step(3);
        check("reset_outputs", int'({key_level, key_press, key_release, key_long, sel}), 0);
        reset = 1'b1;
        step(5);

        // Clean press on key 0, held into a long press (10 ticks of 4 clocks).
        k = cyc;
        key_in[0] = 1'b0;
        expect_ev(0, 0, k + 11, k + 15);
        expect_ev(2, 0, 40, 40);
        step(20);
        check("level0_held", int'(key_level[0]), 1);
        check("sel_after_press", int'(sel), 1);
        step(45);
        j = cyc;
        key_in[0] = 1'b1;
        expect_ev(1, 0, j + 11, j + 15);
        step(20);
        check("sel_single_toggle", int'(sel), 1);
        check("level0_released", int'(key_level[0]), 0);

        // Bounce on key 1: 7 toggles 3 clocks apart, ending low. Earliest possible
        // confirmation uses the last bounce low sampled at k+17, then k+21, k+25.
        k = cyc;
        expect_ev(0, 1, k + 25, k + 33);
        expect_ev(2, 1, 40, 40);
        for (int t = 0; t < 7; t++) begin
            key_in[1] = ~key_in[1];
            if (t < 6) step(3);
        end
        step(22);
        check("level1_after_bounce", int'(key_level[1]), 1);
        step(60);
        j = cyc;
        key_in[1] = 1'b1;
        expect_ev(1, 1, j + 11, j + 15);
        step(20);

        // 6-clock glitch on key 2 spans at most two ticks: nothing may happen.
        key_in[2] = 1'b0;
        step(6);
        key_in[2] = 1'b1;
        step(30);
        check("glitch_level2", int'(key_level[2]), 0);

        // Key 3 release glitch of one tick period: the glitch tick and the return tick
        // both leave lcnt untouched, so key_long arrives 2 ticks (8 clocks) late.
        k = cyc;
        key_in[3] = 1'b0;
        expect_ev(0, 3, k + 11, k + 15);
        expect_ev(2, 3, 48, 48);
        step(25);
        check("level3_held", int'(key_level[3]), 1);
        key_in[3] = 1'b1;
        step(4);
        key_in[3] = 1'b0;
        step(80);
        j = cyc;
        key_in[3] = 1'b1;
        expect_ev(1, 3, j + 11, j + 15);
        step(20);

        // Reset while key 0 is held and confirmed, then a fresh press after reset.
        k = cyc;
        key_in[0] = 1'b0;
        expect_ev(0, 0, k + 11, k + 15);
        step(20);
        check("level0_before_reset", int'(key_level[0]), 1);
        reset = 1'b0;
        #2;
        check("reset_mid_outputs",
              int'({key_level, key_press, key_release, key_long, sel}), 0);
        step(3);
        check("reset_hold_sel", int'(sel), 0);
        reset = 1'b1;
        j = cyc;
        expect_ev(0, 0, j + 11, j + 15);
        expect_ev(2, 0, 40, 40);
        step(60);
        j = cyc;
        key_in[0] = 1'b1;
        expect_ev(1, 0, j + 11, j + 15);
        step(25);

        // Every expected pulse must have been seen.
        while (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_pulse: kind %0d key %0d, required in %0d..%0d, got none",
                     exp_q[0].kind, exp_q[0].key, exp_q[0].lo, exp_q[0].hi);
            void'(exp_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_input_ctrl.md
# key_input_ctrl

Debounced push-button front end for the LED board: the input-side counterpart to the LED output path. Synchronises up to N raw key lines, debounces each against a slow sample tick, and emits clean levels, single-cycle press/release/long-press pulses, and a registered `sel` that toggles on each key-0 press. The outputs feed the mode and select inputs of the LED pattern logic.

## Interface

Parameters:
- `N_KEYS`, 4: number of key inputs (1..8).
- `SAMPLE_DIV`, 50000: clocks per sample tick (1 ms at 50 MHz); must be ≥ 2.
- `STABLE_CNT`, 20: consecutive agreeing samples needed to confirm a press or release; must be ≥ 1.
- `LONG_CNT`, 1000: sample ticks held after press confirmation before `key_long` fires; must be ≥ 1.
- `KEY_ACTIVE_LOW`, 1: 1 means a raw 0 is pressed.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: asynchronous, active-low reset.
- `key_in`, in, N_KEYS: raw, asynchronous button lines.
- `key_level`, out, N_KEYS: debounced pressed level.
- `key_press`, out, N_KEYS: one-cycle pulse on confirmed press.
- `key_release`, out, N_KEYS: one-cycle pulse on confirmed release.
- `key_long`, out, N_KEYS: one-cycle pulse when the long-press threshold is reached.
- `sel`, out, 1: toggles on each `key_press[0]`.

## Operation

- **Reset values:** all outputs 0, all FSMs IDLE, all counters 0, synchroniser flops at the released level.
- **Synchroniser:** each key passes through 2 flops. Polarity is normalised afterwards, so internal `p` = 1 means pressed.
- **Sample tick:**
  - The prescaler counts from 0 to SAMPLE_DIV-1 and wraps.
  - `tick` is high for one clock when the count is SAMPLE_DIV-1.
  - The first tick occurs SAMPLE_DIV clocks after reset deassertion.
- **Per-key FSM:** evaluated only on tick cycles. State and pulses are held between ticks.
  - **IDLE:**
    - `p`=1 → PRESS_WAIT, with `dcnt`=1.
    - If STABLE_CNT=1, go directly to PRESSED and assert `key_press` instead.
  - **PRESS_WAIT:**
    - `p`=1: `dcnt`++. When `dcnt` reaches STABLE_CNT → PRESSED, assert `key_press`, clear `lcnt`.
    - `p`=0 → IDLE, `dcnt`=0. No pulse.
  - **PRESSED:**
    - `p`=1: `lcnt`++. When `lcnt` reaches LONG_CNT → LONG_HELD, assert `key_long`.
    - `p`=0 → RELEASE_WAIT, `dcnt`=1, remember origin = PRESSED.
  - **LONG_HELD:**
    - `p`=0 → RELEASE_WAIT, `dcnt`=1, remember origin = LONG_HELD.
    - `lcnt` is frozen.
  - **RELEASE_WAIT:**
    - `p`=0: `dcnt`++. When `dcnt` reaches STABLE_CNT → IDLE, assert `key_release`.
    - `p`=1: return to the remembered origin state. `lcnt` resumes from its frozen value and is not cleared.
- **`key_level`:** 1 in PRESSED, LONG_HELD and RELEASE_WAIT; 0 in IDLE and PRESS_WAIT.
- **`sel`:** inverts on every clock where `key_press[0]`=1.
- **Independence:** keys are fully independent. Simultaneous presses produce simultaneous pulses, with no priority between keys.
- **Counter widths:**
  - `dcnt` is $clog2(STABLE_CNT+1) bits.
  - `lcnt` is $clog2(LONG_CNT+1) bits.
  - Counters saturate and never wrap.
- **Reset mid-operation:** asynchronous return to the reset values above. A key still held after reset deasserts is re-debounced from IDLE and yields a fresh `key_press`.

## Timing

- Synchroniser latency: 2 clocks.
- Pulses are registered. Each is high for exactly the one clock after the tick edge that causes the transition.
- Press latency from a clean raw edge to `key_press`: between (STABLE_CNT-1)·SAMPLE_DIV+3 and STABLE_CNT·SAMPLE_DIV+3 clocks. Release latency is the same.
- `key_long` fires exactly LONG_CNT ticks after `key_press` if no release glitch occurred.
- `key_level` changes on the same edge as the corresponding press or release pulse.
- `sel` changes one clock after `key_press[0]`.

## Structure

- **Package `key_input_pkg`:**
  - State enum: IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT.
  - Width helper functions.
- **Sub-module `key_debounce_fsm`:**
  - One instance per key, generated N_KEYS times.
  - Contains the synchroniser, polarity normalisation, FSM, `dcnt` and `lcnt`.
- **Top:** holds the single shared prescaler and the `sel` toggle flop.

## Test plan

Bench parameters: SAMPLE_DIV=4, STABLE_CNT=3, LONG_CNT=10, KEY_ACTIVE_LOW=1.

1. **Clean press:** `key_in[0]` goes 1→0 and is held. Required: exactly one `key_press[0]` pulse 11–15 clocks later, `key_level[0]`=1, `sel` goes 0→1.
2. **Bounce:** `key_in[1]` toggles every 3 clocks for 20 clocks, then is held low. Required: exactly one `key_press[1]`, no `key_release[1]`.
3. **Short glitch:** `key_in[2]` low for 6 clocks, then high. Required: no pulses, `key_level[2]` stays 0.
4. **Long press:** hold `key_in[0]`. Required: `key_long[0]` exactly 40 clocks after `key_press[0]`. After release, one `key_release[0]`. `sel` has toggled only once.
5. **Release glitch:** while pressed, raise `key_in[3]` for one tick. Required: no `key_release[3]`, and `key_long[3]` is delayed by the frozen tick.
6. **Reset mid-press:** assert `reset` while key 0 is held, then deassert. Required: all outputs 0 during reset, `sel`=0, and a fresh `key_press[0]` within 15 clocks.
